// File: rtl/convdim1_stream_ctrl.sv
// Purpose : bit-serial valid/ready sequencer around a combinational GF(2) 1-D convolution.
// Latency : last input beat at cycle t, result capture at t+1, first output beat valid at t+2.
// Backpr. : s_ready low outside LOAD; m_valid/m_data/m_last held until the m_ready handshake.
//
// Optional feature macro: CONVCTL_EARLY_LAST_EN
//   When defined, the s_last port exists and a beat carrying s_last ends the
//   frame early. Bits that were never received read as zero. The output frame
//   is still OUTLEN bits long. When the macro is undefined, every frame is
//   exactly INLEN beats and there is no s_last port.
//
// Ports:
//   clk, rst           sole rising-edge clock, synchronous active-high reset
//   kern_wr/kern_data  kernel load; bit k is the coefficient of x^k
//   s_valid/s_ready    input bit stream; the first beat is in[0]
//   s_data, s_last     input bit, and the early end-of-frame flag (optional)
//   m_valid/m_ready    output bit stream; the first beat is out[0]
//   m_data, m_last     output bit; m_last is high with out[OUTLEN-1]
//   busy               low only when idle in LOAD with no beats collected

// Combinational GF(2) convolution: out[i] = XOR_k (in[i-k] & kern[k]).
// Partial products are ANDs and they are summed by XOR, so no carries are formed.
module convdim1 #(
    parameter int INLEN   = 8,
    parameter int KERNLEN = 3
) (
    input  logic [INLEN-1:0]         in_vec,
    input  logic [KERNLEN-1:0]       kern,
    output logic [INLEN+KERNLEN-2:0] out_vec
);
    localparam int OUTLEN = INLEN + KERNLEN - 1;

    always_comb begin
        out_vec = '0;
        for (int i = 0; i < OUTLEN; i++) begin
            for (int k = 0; k < KERNLEN; k++) begin
                // Input positions outside 0..INLEN-1 contribute zero.
                if ((i - k) >= 0 && (i - k) < INLEN) begin
                    out_vec[i] = out_vec[i] ^ (in_vec[i-k] & kern[k]);
                end
            end
        end
    end
endmodule

module convdim1_stream_ctrl #(
    parameter int INLEN   = 8,
    parameter int KERNLEN = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               kern_wr,
    input  logic [KERNLEN-1:0] kern_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_data,
`ifdef CONVCTL_EARLY_LAST_EN
    input  logic               s_last,
`endif
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_data,
    output logic               m_last,
    output logic               busy
);
    localparam int OUTLEN = INLEN + KERNLEN - 1;
    // The counter is wide enough to hold OUTLEN. It never advances past OUTLEN-1.
    localparam int CW     = $clog2(OUTLEN + 1);

    localparam logic [CW-1:0] LAST_IN  = CW'(INLEN - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(OUTLEN - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [INLEN-1:0]    frame_q, frame_d;
    logic [KERNLEN-1:0]  kern_q, kern_d;
    logic [OUTLEN-1:0]   out_q, out_d;
    logic [OUTLEN-1:0]   conv_out;
    logic                frame_end;

    convdim1 #(
        .INLEN   (INLEN),
        .KERNLEN (KERNLEN)
    ) u_conv (
        .in_vec  (frame_q),
        .kern    (kern_q),
        .out_vec (conv_out)
    );

    // A beat accepted in LOAD closes the frame in one of two cases: it fills
    // the last slot, or (when early termination is built in) it carries s_last.
`ifdef CONVCTL_EARLY_LAST_EN
    assign frame_end = s_last || (cnt_q == LAST_IN);
`else
    assign frame_end = (cnt_q == LAST_IN);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            frame_q <= '0;
            kern_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            kern_q  <= kern_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        kern_d  = kern_q;
        out_d   = out_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = 1'b0;
        m_last  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                s_ready = 1'b1;
                // The kernel may change only between frames. A write in the
                // same cycle as the first beat still reaches that frame,
                // because the kernel register is not read until CALC.
                if (kern_wr && cnt_q == '0) begin
                    kern_d = kern_data;
                end
                if (s_valid) begin
                    for (int i = 0; i < INLEN; i++) begin
                        if (cnt_q == CW'(i)) begin
                            frame_d[i] = s_data;
                        end
                    end
                    if (frame_end) begin
                        state_d = ST_CALC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end

            ST_CALC: begin
                out_d   = conv_out;
                state_d = ST_DRAIN;
            end

            ST_DRAIN: begin
                m_valid = 1'b1;
                for (int i = 0; i < OUTLEN; i++) begin
                    if (cnt_q == CW'(i)) begin
                        m_data = out_q[i];
                    end
                end
                m_last = (cnt_q == LAST_OUT);
                if (m_ready) begin
                    if (cnt_q == LAST_OUT) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                        // Clearing the frame here means a short frame (early
                        // s_last) reads zeros in the slots it never wrote,
                        // and no bits from the previous frame leak through.
                        frame_d = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
                frame_d = '0;
            end
        endcase
    end

    assign busy = !(state_q == ST_LOAD && cnt_q == '0);

endmodule

// File: tb/tb_convdim1_stream_ctrl.sv
module tb_convdim1_stream_ctrl;
    localparam int INLEN   = 8;
    localparam int KERNLEN = 3;
    localparam int OUTLEN  = INLEN + KERNLEN - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               kern_wr;
    logic [KERNLEN-1:0] kern_data;
    logic               s_valid;
    logic               s_data;
`ifdef CONVCTL_EARLY_LAST_EN
    logic               s_last;
`endif
    logic               m_ready;
    logic               s_ready, m_valid, m_data, m_last, busy;

    int checks = 0;
    int errors = 0;
    logic [KERNLEN-1:0] cur_kern;   // the kernel the DUT should hold
    logic [OUTLEN-1:0]  got;

    always #5 clk = ~clk;

    convdim1_stream_ctrl #(.INLEN(INLEN), .KERNLEN(KERNLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .kern_wr   (kern_wr),
        .kern_data (kern_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
`ifdef CONVCTL_EARLY_LAST_EN
        .s_last    (s_last),
`endif
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy)
    );

    // Reference model: a carry-less polynomial product, built as the XOR of
    // shifted copies of the frame, one copy for each set kernel bit.
    function automatic logic [OUTLEN-1:0] model(input logic [INLEN-1:0] f,
                                                input logic [KERNLEN-1:0] k);
        logic [OUTLEN-1:0] acc;
        acc = '0;
        for (int kk = 0; kk < KERNLEN; kk++)
            if (k[kk]) acc = acc ^ (OUTLEN'(f) << kk);
        return acc;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic write_kernel(input logic [KERNLEN-1:0] k);
        kern_wr   = 1'b1;
        kern_data = k;
        step();
        kern_wr   = 1'b0;
        cur_kern  = k;
    endtask

    // Sends nbeats bits of f, LSB first. If kw is set, a kernel write goes out
    // together with the first beat. A frame shorter than INLEN ends with s_last.
    task automatic send_frame(input logic [INLEN-1:0] f, input int nbeats,
                              input bit kw, input logic [KERNLEN-1:0] kv);
        for (int b = 0; b < nbeats; b++) begin
            int t;
            s_valid   = 1'b1;
            s_data    = f[b];
            kern_wr   = kw && (b == 0);
            kern_data = kv;
`ifdef CONVCTL_EARLY_LAST_EN
            s_last    = (b == nbeats - 1) && (nbeats < INLEN);
`endif
            t = 0;
            while (!s_ready && t < 200) begin
                step();
                t++;
            end
            if (!s_ready) begin
                errors++;
                $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
            end
            step();
        end
        s_valid = 1'b0;
        kern_wr = 1'b0;
`ifdef CONVCTL_EARLY_LAST_EN
        s_last  = 1'b0;
`endif
        if (kw) cur_kern = kv;
    endtask

    // Called right after the edge that accepted the last beat.
    task automatic check_latency;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL calc_cycle: m_valid=%0b busy=%0b s_ready=%0b required 0 1 0",
                     m_valid, busy, s_ready);
        end
        step();
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid_latency: m_valid=%0b required 1", m_valid);
        end
    endtask

    // mode 0: m_ready always high, 1: m_ready toggling, 2: m_ready random.
    task automatic collect(input int mode, output logic [OUTLEN-1:0] bits);
        int   idx;
        int   t;
        logic stalled;
        logic pd, pl;
        idx = 0; t = 0; stalled = 1'b0; pd = 1'b0; pl = 1'b0;
        bits = '0;
        while (idx < OUTLEN && t < 2000) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (t % 2) == 1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
                    errors++;
                    $display("FAIL stall_hold: valid/data/last=%0b%0b%0b required 1%0b%0b",
                             m_valid, m_data, m_last, pd, pl);
                end
            end
            if (m_valid === 1'b1) begin
                if (s_valid) begin
                    checks++;
                    if (s_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL s_ready_in_drain: s_ready=%0b required 0", s_ready);
                    end
                end
                if (m_ready) begin
                    bits[idx] = m_data;
                    checks++;
                    if (m_last !== 1'(idx == OUTLEN - 1)) begin
                        errors++;
                        $display("FAIL m_last_beat%0d: m_last=%0b required %0b",
                                 idx, m_last, (idx == OUTLEN - 1));
                    end
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = m_data;
                    pl = m_last;
                end
            end
            step();
            t++;
        end
        m_ready = 1'b0;
        if (idx < OUTLEN) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats required %0d", idx, OUTLEN);
        end
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_frame_idle: m_valid=%0b s_ready=%0b busy=%0b required 0 1 0",
                     m_valid, s_ready, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; kern_wr = 1'b0; kern_data = '0; s_valid = 1'b0; s_data = 1'b0;
        m_ready = 1'b0;
`ifdef CONVCTL_EARLY_LAST_EN
        s_last = 1'b0;
`endif
        cur_kern = '0;
        step();
        step();
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 ||
            m_data !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: s_ready=%0b m_valid=%0b busy=%0b m_data=%0b m_last=%0b required 1 0 0 0 0",
                     s_ready, m_valid, busy, m_data, m_last);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_kernel111;
        write_kernel(3'b111);
        send_frame(8'b0000_0001, INLEN, 1'b0, '0);
        check_latency();
        collect(0, got);
        checks++;
        if (got !== 10'b00_0000_0111) begin
            errors++;
            $display("FAIL kernel111: out=%b required %b", got, 10'b00_0000_0111);
        end
    endtask

    task automatic test_kernel101;
        write_kernel(3'b101);
        send_frame(8'hFF, INLEN, 1'b0, '0);
        check_latency();
        collect(0, got);
        checks++;
        if (got !== 10'b11_0000_0011) begin
            errors++;
            $display("FAIL kernel101: out=%b required %b", got, 10'b11_0000_0011);
        end
    endtask

    task automatic test_backpressure;
        send_frame(8'h3C, INLEN, 1'b0, '0);
        s_valid = 1'b1;
        s_data  = 1'b1;
        check_latency();
        collect(1, got);
        s_valid = 1'b0;
        checks++;
        if (got !== model(8'h3C, cur_kern)) begin
            errors++;
            $display("FAIL backpressure: out=%b required %b", got, model(8'h3C, cur_kern));
        end
    endtask

    task automatic test_kernel_write_rules;
        write_kernel(3'b111);
        send_frame(8'h5A, INLEN, 1'b0, '0);
        check_latency();
        kern_wr = 1'b1;
        kern_data = 3'b001;
        step();
        step();
        kern_wr = 1'b0;
        collect(2, got);
        checks++;
        if (got !== model(8'h5A, 3'b111)) begin
            errors++;
            $display("FAIL kern_wr_in_drain_frame: out=%b required %b", got, model(8'h5A, 3'b111));
        end
        send_frame(8'hA5, INLEN, 1'b0, '0);
        check_latency();
        collect(0, got);
        checks++;
        if (got !== model(8'hA5, 3'b111)) begin
            errors++;
            $display("FAIL old_kernel_kept: out=%b required %b", got, model(8'hA5, 3'b111));
        end
        send_frame(8'hA5, INLEN, 1'b1, 3'b001);
        check_latency();
        collect(0, got);
        checks++;
        if (got !== 10'h0A5) begin
            errors++;
            $display("FAIL kern_wr_first_beat: out=%b required %b", got, 10'h0A5);
        end
    endtask

    task automatic test_reset_mid_drain;
        write_kernel(3'b111);
        send_frame(INLEN'($urandom), INLEN, 1'b0, '0);
        check_latency();
        m_ready = 1'b1;
        step(); step(); step();
        m_ready = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || m_data !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drain: m_valid=%0b s_ready=%0b busy=%0b m_data=%0b required 0 1 0 0",
                     m_valid, s_ready, busy, m_data);
        end
        rst = 1'b0;
        cur_kern = '0;
        step();
        send_frame(8'hFF, INLEN, 1'b0, '0);
        check_latency();
        collect(0, got);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL kernel_cleared_by_reset: out=%b required 0", got);
        end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 16; n++) begin
            logic [INLEN-1:0]   f;
            logic [KERNLEN-1:0] kv;
            bit                 kw;
            f  = INLEN'($urandom);
            kv = KERNLEN'($urandom);
            kw = 1'($urandom_range(0, 1));
            send_frame(f, INLEN, kw, kv);
            check_latency();
            collect(2, got);
            checks++;
            if (got !== model(f, cur_kern)) begin
                errors++;
                $display("FAIL random_frame%0d: out=%b required %b", n, got, model(f, cur_kern));
            end
        end
    endtask

`ifdef CONVCTL_EARLY_LAST_EN
    task automatic test_early_last;
        write_kernel(3'b011);
        send_frame(8'b0000_0011, 2, 1'b0, '0);
        check_latency();
        collect(0, got);
        checks++;
        if (got !== 10'b00_0000_0101) begin
            errors++;
            $display("FAIL early_last: out=%b required %b", got, 10'b00_0000_0101);
        end
        for (int n = 0; n < 8; n++) begin
            logic [INLEN-1:0] f;
            int               nb;
            nb = $urandom_range(1, INLEN);
            f  = INLEN'($urandom);
            send_frame(f, nb, 1'b1, KERNLEN'($urandom));
            f  = f & INLEN'((1 << nb) - 1);
            check_latency();
            collect(2, got);
            checks++;
            if (got !== model(f, cur_kern)) begin
                errors++;
                $display("FAIL early_last_rand%0d: out=%b required %b", n, got, model(f, cur_kern));
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_kernel111();
        test_kernel101();
        test_backpressure();
        test_kernel_write_rules();
        test_reset_mid_drain();
        test_back_to_back();
`ifdef CONVCTL_EARLY_LAST_EN
        test_early_last();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
